ahb_slave_mem: RTL and testbench

Synthesizable AHB-Lite subordinate that answers the transfers issued by the bridge's AHB master tasks: single reads and writes plus INCR bursts. Backed by an internal 32-bit word memory, it provides a standalone responder for bring-up and for checking the master before the APB side is attached. It supports:
- a configurable number of wait states per data phase;
- byte, halfword and word lanes;
- a two-cycle ERROR response for unmapped or misaligned accesses.

---
 rtl/ahb_pkg.sv | 36 +++
 rtl/ahb_mem_ram.sv | 26 ++
 rtl/ahb_slave_mem.sv | 151 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and the byte-lane helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } ahb_state_e;

    // Little-endian byte enables for a legal size/offset pair; illegal sizes enable nothing.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
        logic [3:0] mask;
        unique case (size)
            HSIZE_BYTE: mask = 4'b0001 << offs;
            HSIZE_HALF: mask = offs[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_mem_ram.sv
// Word-organised RAM: byte-enable synchronous write port, asynchronous read port.
module ahb_mem_ram #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // Commit only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder with programmable wait states, byte lanes and two-cycle ERROR.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hready_in,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned WORD_W = ADDR_W - 2;

    ahb_state_e        state_q, state_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       hrdata_q;

    logic              accept;
    logic              take;
    logic              addr_err;
    logic              bypass_hit;
    logic [3:0]        wr_be;
    logic [31:0]       wr_mask;
    logic [31:0]       ram_rdata;
    logic [31:0]       rd_merged;
    logic [WORD_W-1:0] rd_word;

    assign accept = hready_in & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
    // Only the ready states ever look at a new address phase.
    assign take   = accept & hreadyout;

    assign addr_err = (haddr[31:ADDR_W] != BASE_ADDR[31:ADDR_W])
                    | (hsize > HSIZE_WORD)
                    | ((hsize == HSIZE_HALF) & haddr[0])
                    | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));

    assign wr_be   = (state_q == StData && write_q) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
    assign wr_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    assign rd_word = haddr[ADDR_W-1:2];

    // A read sampled while a write to the same word completes sees the merged new data.
    assign bypass_hit = (wr_be != 4'b0000) && (addr_q[ADDR_W-1:2] == rd_word);
    assign rd_merged  = bypass_hit ? ((ram_rdata & ~wr_mask) | (hwdata & wr_mask)) : ram_rdata;

    ahb_mem_ram #(
        .AW (WORD_W)
    ) u_ram (
        .clk   (hclk),
        .be    (wr_be),
        .waddr (addr_q[ADDR_W-1:2]),
        .wdata (hwdata),
        .raddr (rd_word),
        .rdata (ram_rdata)
    );

    // Next-state, wait counting and handshake outputs.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hreadyout  = 1'b1;
        hresp      = HRESP_OKAY;
        unique case (state_q)
            StIdle, StData, StErr2: begin
                if (state_q == StErr2) begin
                    hresp = HRESP_ERROR;
                end
                state_d    = StIdle;
                wait_cnt_d = 3'd0;
                if (accept) begin
                    if (addr_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = StWait;
                        wait_cnt_d = 3'd1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StWait: begin
                hreadyout = 1'b0;
                if (wait_cnt_q == 3'(WAIT_STATES)) begin
                    state_d    = StData;
                    wait_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data is live in a read DATA cycle, zero during ERROR, otherwise held.
    always_comb begin
        hrdata = hrdata_q;
        if (state_q == StData && !write_q) begin
            hrdata = rbuf_q;
        end else if (state_q == StErr1 || state_q == StErr2) begin
            hrdata = '0;
        end
    end

    // State, captured address phase and read-data holding registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= StIdle;
            wait_cnt_q <= 3'd0;
            addr_q     <= '0;
            size_q     <= 3'd0;
            write_q    <= 1'b0;
            rbuf_q     <= '0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (take) begin
                addr_q  <= haddr[ADDR_W-1:0];
                size_q  <= hsize;
                write_q <= hwrite;
            end
            if (take && !hwrite && !addr_err) begin
                rbuf_q <= rd_merged;
            end
            if (state_q == StData && !write_q) begin
                hrdata_q <= rbuf_q;
            end else if (state_q == StErr1 || state_q == StErr2) begin
                hrdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: two responders (0 and 2 wait states) share one driven bus, selected by sel.
module tb_ahb_slave_mem;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        bit          err;
        bit          rd;
        bit          chk;
        logic [31:0] data;
        int          stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        sel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans0, htrans2;
    logic        ho0, ho2, hr0, hr2;
    logic [31:0] rd0, rd2;
    logic        hready, hresp;
    logic [31:0] hrdata;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        cur;
    bit          in_dp = 0;
    int          stall = 0;
    logic [31:0] model [2][256];
    bit          known [2][256];

    always #5 clk = ~clk;

    assign htrans0 = sel ? 2'b00 : htrans;
    assign htrans2 = sel ? htrans : 2'b00;
    assign hready  = sel ? ho2 : ho0;
    assign hresp   = sel ? hr2 : hr0;
    assign hrdata  = sel ? rd2 : rd0;

    ahb_slave_mem #(.BASE_ADDR(BASE), .ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .hclk(clk), .hresetn(hresetn), .hready_in(ho0), .htrans(htrans0), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hreadyout(ho0), .hresp(hr0),
        .hrdata(rd0)
    );

    ahb_slave_mem #(.BASE_ADDR(BASE), .ADDR_W(10), .WAIT_STATES(2)) u_dut2 (
        .hclk(clk), .hresetn(hresetn), .hready_in(ho2), .htrans(htrans2), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hreadyout(ho2), .hresp(hr2),
        .hrdata(rd2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: expected response of one address phase, and memory effect of a write.
    function automatic exp_t model_xfer(input logic wr, input logic [2:0] sz,
                                        input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   s;
        int   w;
        int   n;
        s = sel ? 1 : 0;
        w = int'(a[9:2]);
        e.err = (a[31:10] != BASE[31:10]) || (sz > 3'd2) || (sz == 3'd1 && a[0])
                || (sz == 3'd2 && a[1:0] != 2'b00);
        e.rd    = !wr;
        e.chk   = 0;
        e.data  = '0;
        e.stall = e.err ? 1 : (sel ? 2 : 0);
        if (!e.err) begin
            if (wr) begin
                n = 1 << sz;
                for (int k = 0; k < n; k++) begin
                    int b;
                    b = int'(a[1:0]) + k;
                    model[s][w][8*b +: 8] = wd[8*b +: 8];
                end
                if (n == 4) known[s][w] = 1;
            end else begin
                e.chk  = known[s][w];
                e.data = model[s][w];
            end
        end
        return e;
    endfunction

    // Drive one address phase, wait for it to be sampled, then drive its write data.
    task automatic xfer(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        logic r;
        int   n;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        n = 0;
        do begin
            @(negedge clk);
            r = hready;
            @(posedge clk);
            n++;
        end while (!r && n < 40);
        if (!r) begin
            fails++;
            $display("FAIL timeout: hready still 0 after %0d cycles, expected 1", n);
            $fatal(1, "bus stuck");
        end
        if (tr[1]) sb.push_back(model_xfer(wr, sz, a, wd));
        #1;
        hwdata = wd;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) xfer(2'd0, 1'b0, 3'd0, BASE, 32'h0);
    endtask

    task automatic directed();
        for (int w = 0; w < 16; w++) xfer(2'd2, 1'b1, 3'd2, BASE + 32'(4 * w), $urandom);
        idle(1);
        // byte write into lane 2, then full-word read
        xfer(2'd2, 1'b1, 3'd0, BASE + 32'h2, 32'h00A5_0000);
        xfer(2'd2, 1'b0, 3'd2, BASE, 32'h0);
        idle(1);
        // INCR byte burst filling word 0, immediately read back
        xfer(2'd2, 1'b1, 3'd0, BASE + 32'h0, 32'h0000_0011);
        xfer(2'd3, 1'b1, 3'd0, BASE + 32'h1, 32'h0000_2200);
        xfer(2'd3, 1'b1, 3'd0, BASE + 32'h2, 32'h0033_0000);
        xfer(2'd3, 1'b1, 3'd0, BASE + 32'h3, 32'h4400_0000);
        xfer(2'd2, 1'b0, 3'd2, BASE, 32'h0);
        idle(1);
        // write then read of the same word back to back
        xfer(2'd2, 1'b1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF);
        xfer(2'd2, 1'b0, 3'd2, BASE + 32'h10, 32'h0);
        idle(1);
        // halfword write to the upper lanes, then read
        xfer(2'd2, 1'b1, 3'd1, BASE + 32'h16, 32'hCAFE_0000);
        xfer(2'd2, 1'b0, 3'd2, BASE + 32'h14, 32'h0);
        idle(1);
        // unmapped address, misaligned word write, then confirm word 0 unchanged
        xfer(2'd2, 1'b0, 3'd2, 32'h9000_0000, 32'h0);
        idle(1);
        xfer(2'd2, 1'b1, 3'd2, BASE + 32'h1, 32'hFFFF_FFFF);
        idle(1);
        xfer(2'd2, 1'b0, 3'd2, BASE, 32'h0);
        idle(2);
    endtask

    task automatic random_run(input int count);
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < count; i++) begin
            r  = $urandom_range(0, 9);
            tr = (r < 2) ? 2'd0 : (r < 3) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            a  = BASE + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            xfer(tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
        end
        idle(3);
    endtask

    // Monitor: completes data phases against the scoreboard, checks idle cycles as OKAY.
    always @(negedge clk) begin
        if (!hresetn) begin
            in_dp = 0;
            stall = 0;
            sb.delete();
        end else begin
            if (in_dp) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: data phase seen, expected none");
                    in_dp = 0;
                end else if (!hready) begin
                    stall++;
                    check("stall_hresp", 32'(hresp), 32'(sb[0].err));
                end else begin
                    cur = sb.pop_front();
                    check("hresp", 32'(hresp), 32'(cur.err));
                    check("wait_cycles", 32'(stall), 32'(cur.stall));
                    if (cur.err) check("err_hrdata", hrdata, 32'h0);
                    else if (cur.rd && cur.chk) check("hrdata", hrdata, cur.data);
                    in_dp = 0;
                end
            end else begin
                check("idle_okay", 32'({hresp, hready}), 32'h1);
            end
            if (hready && htrans[1]) begin
                in_dp = 1;
                stall = 0;
            end
        end
    end

    initial begin
        hresetn = 1'b0;
        sel     = 1'b0;
        htrans  = 2'd0;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        haddr   = BASE;
        hwdata  = 32'h0;
        #1;
        check("rst0_hreadyout", 32'(ho0), 32'h1);
        check("rst0_hresp", 32'(hr0), 32'h0);
        check("rst0_hrdata", rd0, 32'h0);
        repeat (2) @(negedge clk);
        hresetn = 1'b1;
        @(posedge clk);
        #1;

        directed();
        random_run(150);

        sel = 1'b1;
        directed();
        xfer(2'd2, 1'b0, 3'd2, BASE + 32'h4, 32'h0);
        idle(1);
        random_run(150);

        // Reset while a write sits in its wait states: outputs clear at once, no commit.
        xfer(2'd2, 1'b1, 3'd2, BASE + 32'h20, 32'h1234_5678);
        xfer(2'd2, 1'b0, 3'd2, BASE + 32'h20, 32'h0);
        idle(2);
        htrans = 2'd2;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = BASE + 32'h20;
        @(posedge clk);
        #1;
        htrans  = 2'd0;
        hwdata  = 32'hFFFF_FFFF;
        hresetn = 1'b0;
        #1;
        check("rst2_hreadyout", 32'(ho2), 32'h1);
        check("rst2_hresp", 32'(hr2), 32'h0);
        check("rst2_hrdata", rd2, 32'h0);
        check("rst0b_hreadyout", 32'(ho0), 32'h1);
        check("rst0b_hresp", 32'(hr0), 32'h0);
        check("rst0b_hrdata", rd0, 32'h0);
        repeat (2) @(negedge clk);
        hresetn = 1'b1;
        @(posedge clk);
        #1;
        xfer(2'd2, 1'b0, 3'd2, BASE + 32'h20, 32'h0);
        idle(3);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
